// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer
// Command conditioning ahead of the SR flip-flop: each raw request is
// synchronised, debounced, rising-edge detected and then arbitrated into
// one-cycle s/r pulses.
// Arbitration makes clear win over set.
// It guarantees at least one idle cycle between pulses.
// As a result, s and r are never high together.
// Optional build macro: SR_CONFLICT_FLAG_EN adds the 'conflict' output.
// 'conflict' marks an r pulse that was issued while a set request was also pending.

module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy
`ifdef SR_CONFLICT_FLAG_EN
  ,
  output logic conflict
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PULSE_S = 2'b01,
    PULSE_R = 2'b10
  } state_t;

  // Channel index 0 carries set, index 1 carries clear.
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       stable_r;
  logic [1:0]       stable_d_r;
  logic [CNT_W-1:0] cnt_r [2];
  logic [1:0]       rise_s;

  state_t state_r;
  logic   pend_set_r;
  logic   pend_clr_r;
  logic   s_r;
  logic   r_r;

  // Two-flop synchroniser for both raw request lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {clr_in, set_in};
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r   <= 2'b00;
      stable_d_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      stable_d_r <= stable_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != stable_r[i]) begin
          if (cnt_r[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_r[i] <= sync2_r[i];
            cnt_r[i]    <= {CNT_W{1'b0}};
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          end
        end else begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end
      end
    end
  end

  // A debounced 0->1 transition becomes a pending request one edge later; falling edges are dropped.
  assign rise_s = stable_r & ~stable_d_r;

  // Arbiter FSM: clear has priority; every pulse lasts one cycle and is followed by IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      pend_set_r <= 1'b0;
      pend_clr_r <= 1'b0;
      s_r        <= 1'b0;
      r_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pend_clr_r) begin
            state_r    <= PULSE_R;
            r_r        <= 1'b1;
            s_r        <= 1'b0;
            pend_clr_r <= rise_s[1];
            pend_set_r <= pend_set_r | rise_s[0];
          end else if (pend_set_r) begin
            state_r    <= PULSE_S;
            s_r        <= 1'b1;
            r_r        <= 1'b0;
            pend_set_r <= rise_s[0];
            pend_clr_r <= rise_s[1];
          end else begin
            state_r    <= IDLE;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            pend_set_r <= rise_s[0];
            pend_clr_r <= rise_s[1];
          end
        end
        PULSE_S, PULSE_R: begin
          // Edges arriving here are latched and served once back in IDLE.
          state_r    <= IDLE;
          s_r        <= 1'b0;
          r_r        <= 1'b0;
          pend_set_r <= pend_set_r | rise_s[0];
          pend_clr_r <= pend_clr_r | rise_s[1];
        end
        default: begin
          state_r    <= IDLE;
          s_r        <= 1'b0;
          r_r        <= 1'b0;
          pend_set_r <= pend_set_r | rise_s[0];
          pend_clr_r <= pend_clr_r | rise_s[1];
        end
      endcase
    end
  end

  assign s    = s_r;
  assign r    = r_r;
  assign busy = pend_set_r | pend_clr_r | (state_r != IDLE);

`ifdef SR_CONFLICT_FLAG_EN
  logic conflict_r;

  // Flag an r pulse that was granted while a set request was also waiting; aligned with r.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_r <= 1'b0;
    end else if ((state_r == IDLE) && pend_clr_r) begin
      conflict_r <= pend_set_r;
    end else begin
      conflict_r <= 1'b0;
    end
  end

  assign conflict = conflict_r;
`else
  // Without the flag, simultaneous requests are arbitrated the same way but not reported.
`endif

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer (DEBOUNCE_CYCLES=4).
// Timing reference: after raising an input just past a clock edge, step N samples
// the outputs 1 ns after edge N-1, so a pulse issued after edge 7 is seen at step 8.

module tb_sr_cmd_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic set_in;
  logic clr_in;
  logic s;
  logic r;
  logic busy;
`ifdef SR_CONFLICT_FLAG_EN
  logic conflict;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  int s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set_in  (set_in),
    .clr_in  (clr_in),
    .s       (s),
    .r       (r),
    .busy    (busy)
`ifdef SR_CONFLICT_FLAG_EN
    ,
    .conflict(conflict)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles and summarise pulse activity (first indices are 1-based, 0 = none).
  task automatic run_watch(input int n,
                           output int sc, output int sf, output int rc, output int rf,
                           output int bc, output int busyc, output int cc, output int cf);
    sc = 0; sf = 0; rc = 0; rf = 0; bc = 0; busyc = 0; cc = 0; cf = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (s === 1'b1) begin
        sc++;
        if (sf == 0) sf = i;
      end
      if (r === 1'b1) begin
        rc++;
        if (rf == 0) rf = i;
      end
      if ((s === 1'b1) && (r === 1'b1)) bc++;
      if (busy === 1'b1) busyc++;
`ifdef SR_CONFLICT_FLAG_EN
      if (conflict === 1'b1) begin
        cc++;
        if (cf == 0) cf = i;
      end
`endif
    end
  endtask

  initial begin
    reset  = 1'b1;
    set_in = 1'b0;
    clr_in = 1'b0;

    // Test 1: reset for 3 cycles, then idle inputs for 20 cycles.
    step(); step(); step();
    check_val("t1_reset_s", int'(s), 0);
    check_val("t1_reset_r", int'(r), 0);
    check_val("t1_reset_busy", int'(busy), 0);
    reset = 1'b0;
    run_watch(20, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t1_idle_s", s_cnt, 0);
    check_val("t1_idle_r", r_cnt, 0);
    check_val("t1_idle_busy", busy_cnt, 0);

    // Test 2: set held high -> one s pulse at step 8, busy during steps 7..8.
    set_in = 1'b1;
    run_watch(12, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t2_s_first", s_first, 8);
    check_val("t2_s_cnt", s_cnt, 1);
    check_val("t2_r_cnt", r_cnt, 0);
    check_val("t2_busy_cycles", busy_cnt, 2);
    check_val("t2_busy_end", int'(busy), 0);
    set_in = 1'b0;
    run_watch(10, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t2_fall_s_cnt", s_cnt, 0);
    check_val("t2_fall_busy", busy_cnt, 0);

    // Test 3: clr bounces 1,0,1,0 then settles -> one r pulse 8 steps after settle.
    clr_in = 1'b1; step();
    clr_in = 1'b0; step();
    clr_in = 1'b1; step();
    clr_in = 1'b0; step();
    check_val("t3_bounce_r", int'(r), 0);
    clr_in = 1'b1;
    run_watch(12, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t3_r_first", r_first, 8);
    check_val("t3_r_cnt", r_cnt, 1);
    check_val("t3_s_cnt", s_cnt, 0);
    clr_in = 1'b0;
    run_watch(10, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t3_fall_r_cnt", r_cnt, 0);

    // Test 4: simultaneous rise -> r at step 8, gap, s at step 10.
    set_in = 1'b1;
    clr_in = 1'b1;
    run_watch(14, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t4_r_first", r_first, 8);
    check_val("t4_s_first", s_first, 10);
    check_val("t4_r_cnt", r_cnt, 1);
    check_val("t4_s_cnt", s_cnt, 1);
    check_val("t4_s_and_r", both_cnt, 0);
    check_val("t4_busy_cycles", busy_cnt, 4);
`ifdef SR_CONFLICT_FLAG_EN
    check_val("t4_conflict_first", c_first, 8);
    check_val("t4_conflict_cnt", c_cnt, 1);
`endif
    set_in = 1'b0;
    clr_in = 1'b0;
    run_watch(10, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t4_fall_pulses", s_cnt + r_cnt, 0);

    // Test 5: reset on the edge that would issue s -> no pulse; then a fresh pulse.
    set_in = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check_val("t5_busy_pending", int'(busy), 1);
    reset = 1'b1;
    step();
    check_val("t5_reset_s", int'(s), 0);
    check_val("t5_reset_busy", int'(busy), 0);
    reset = 1'b0;
    run_watch(12, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t5_s_first", s_first, 8);
    check_val("t5_s_cnt", s_cnt, 1);
    check_val("t5_busy_cycles", busy_cnt, 2);
    set_in = 1'b0;
    run_watch(10, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t5_fall_s_cnt", s_cnt, 0);

    // Test 6a: 2-cycle set glitch is rejected.
    set_in = 1'b1; step(); step();
    set_in = 1'b0;
    run_watch(14, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t6_glitch_s_cnt", s_cnt, 0);
    check_val("t6_glitch_busy", busy_cnt, 0);

    // Test 6b: set edge latched during PULSE_R -> r at step 6, s at step 8.
    clr_in = 1'b1; step(); step();
    set_in = 1'b1;
    run_watch(12, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t6_r_first", r_first, 6);
    check_val("t6_s_first", s_first, 8);
    check_val("t6_r_cnt", r_cnt, 1);
    check_val("t6_s_cnt", s_cnt, 1);
    check_val("t6_s_and_r", both_cnt, 0);
`ifdef SR_CONFLICT_FLAG_EN
    check_val("t6_conflict_cnt", c_cnt, 0);
`endif
    set_in = 1'b0;
    clr_in = 1'b0;
    run_watch(10, s_cnt, s_first, r_cnt, r_first, both_cnt, busy_cnt, c_cnt, c_first);
    check_val("t6_drain_busy", busy_cnt, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
